store_buffer: RTL and testbench

- Committed-store buffer between the WB/commit stage and the dcache write port.
- Accepts one committed store per cycle as a store_req_t and holds it in an in-order circular FIFO.
- Drains entries oldest-first to the dcache over a valid/ready handshake.
- Provides combinational byte-merged load forwarding to the MEM stage, so loads observe stores that are still buffered.

---
 rtl/store_buffer.sv | 130 +++++++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Committed-store buffer: in-order circular FIFO that drains to the dcache write port
// and forwards buffered bytes (oldest-to-youngest merge) to MEM-stage loads.

package store_buffer_pkg;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;

  typedef struct packed {
    logic                       valid;
    logic [SB_DATA_WIDTH/8-1:0] wstrb;
    logic [SB_ADDR_WIDTH-1:0]   waddr;
    logic [SB_DATA_WIDTH-1:0]   wdata;
  } store_req_t;
endpackage

module store_buffer #(
  parameter int DEPTH      = 8,
  // Must agree with the field widths of store_buffer_pkg::store_req_t.
  parameter int ADDR_WIDTH = store_buffer_pkg::SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = store_buffer_pkg::SB_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  store_buffer_pkg::store_req_t     store_req_i,
  output logic                             store_ready_o,
  output store_buffer_pkg::store_req_t     dcache_req_o,
  input  logic                             dcache_ready_i,
  input  logic                             query_valid_i,
  input  logic [ADDR_WIDTH-1:0]            query_addr_i,
  output logic                             query_hit_o,
  output logic [DATA_WIDTH/8-1:0]          query_strb_o,
  output logic [DATA_WIDTH-1:0]            query_data_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [CNT_WIDTH-1:0]  count;

  logic [STRB_WIDTH-1:0] wstrb_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] waddr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];

  logic                  full;
  logic                  empty;
  logic                  enq;
  logic                  deq;
  logic [STRB_WIDTH-1:0] fwd_strb;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Full/empty come from the counter; head == tail is ambiguous once pointers wrap.
  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign empty = (count == '0);
  assign enq   = store_req_i.valid && !full;
  assign deq   = !empty && dcache_ready_i;

  assign store_ready_o = !full;
  assign full_o        = full;
  assign empty_o       = empty;
  assign count_o       = count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_WIDTH'(1);
      if (deq) head <= head + PTR_WIDTH'(1);
      count <= count + CNT_WIDTH'(enq) - CNT_WIDTH'(deq);
    end
  end

  // NOTE: payload RAM has no reset; occupancy is tracked by count, so stale
  // contents are never observed and the array can map onto plain storage.
  always_ff @(posedge clk) begin
    if (enq) begin
      wstrb_mem[tail] <= store_req_i.wstrb;
      waddr_mem[tail] <= store_req_i.waddr;
      wdata_mem[tail] <= store_req_i.wdata;
    end
  end

  always_comb begin
    dcache_req_o       = '0;
    dcache_req_o.valid = !empty;
    dcache_req_o.wstrb = wstrb_mem[head];
    dcache_req_o.waddr = waddr_mem[head];
    dcache_req_o.wdata = wdata_mem[head];
  end

  // Walk entries from head (oldest) to youngest so later strobed bytes win.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin : fwd_merge
    logic [PTR_WIDTH-1:0] idx;
    fwd_strb = '0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_WIDTH'(i);
      if ((CNT_WIDTH'(i) < count) &&
          (waddr_mem[idx][ADDR_WIDTH-1:2] == query_addr_i[ADDR_WIDTH-1:2])) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wstrb_mem[idx][b]) begin
            fwd_strb[b]         = 1'b1;
            fwd_data[8*b +: 8]  = wdata_mem[idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign query_strb_o = query_valid_i ? fwd_strb : '0;
  assign query_data_o = query_valid_i ? fwd_data : '0;
  assign query_hit_o  = query_valid_i && (|fwd_strb);

  // Byte offset within the word is irrelevant to word-granular matching.
  logic unused_query_offset;
  assign unused_query_offset = ^query_addr_i[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard queue filled at issue time,
// drained by an independent monitor on each dcache handshake.

module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  store_req_t    store_req;
  logic          store_ready;
  store_req_t    dcache_req;
  logic          dcache_ready;
  logic          query_valid;
  logic [AW-1:0] query_addr;
  logic          query_hit;
  logic [SW-1:0] query_strb;
  logic [DW-1:0] query_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .store_req_i    (store_req),
    .store_ready_o  (store_ready),
    .dcache_req_o   (dcache_req),
    .dcache_ready_i (dcache_ready),
    .query_valid_i  (query_valid),
    .query_addr_i   (query_addr),
    .query_hit_o    (query_hit),
    .query_strb_o   (query_strb),
    .query_data_o   (query_data),
    .full_o         (full),
    .empty_o        (empty),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted dcache transfer must match the oldest expected store.
  always @(negedge clk) begin
    if (rst && dcache_req.valid && dcache_ready) begin
      if (exp_q.size() == 0) begin
        check("drain_with_empty_scoreboard", dcache_req.valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("drain_addr", dcache_req.waddr, e.addr);
        check("drain_strb", dcache_req.wstrb, e.strb);
        check("drain_data", dcache_req.wdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_store(input logic v, input logic [SW-1:0] s,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic expect_accept);
    store_req = '{valid: v, wstrb: s, waddr: a, wdata: d};
    if (v && expect_accept) exp_q.push_back('{strb: s, addr: a, data: d});
  endtask

  task automatic idle_store();
    store_req = '0;
  endtask

  task automatic drain(input int budget);
    dcache_ready = 1'b1;
    for (int n = 0; n < budget && !empty; n++) step();
    dcache_ready = 1'b0;
    sample();
    check("drained_empty", empty, 1'b1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_query(input string name, input logic h, input logic [SW-1:0] s, input logic [DW-1:0] d);
    check({name, "_hit"},  query_hit,  h);
    check({name, "_strb"}, query_strb, s);
    check({name, "_data"}, query_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    store_req    = '0;
    dcache_ready = 1'b0;
    query_valid  = 1'b1;
    query_addr   = 32'h0000_1000;
    repeat (2) @(posedge clk);

    // Reset state, with a live query to show forwarding is silent.
    sample();
    check("rst_store_ready", store_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 0);
    check("rst_dcache_valid", dcache_req.valid, 1'b0);
    check_query("rst_query", 1'b0, 4'h0, 32'h0);
    query_valid = 1'b0;
    step();
    rst = 1'b1;

    // 1: single store, stall, then pop.
    set_store(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    step();
    idle_store();
    sample();
    check("t1_count", count, 1);
    for (int c = 0; c < 5; c++) begin
      check("t1_hold_valid", dcache_req.valid, 1'b1);
      check("t1_hold_addr", dcache_req.waddr, 32'h0000_1000);
      check("t1_hold_strb", dcache_req.wstrb, 4'hF);
      check("t1_hold_data", dcache_req.wdata, 32'hDEAD_BEEF);
      sample();
    end
    step();
    dcache_ready = 1'b1;
    step();
    dcache_ready = 1'b0;
    sample();
    check("t1_empty_after_pop", empty, 1'b1);
    check("t1_scoreboard", exp_q.size(), 0);

    // 2: fill to DEPTH (pointers start at 1, so this wraps), then valid+ready while full.
    for (int i = 0; i < DEPTH; i++) begin
      set_store(1'b1, 4'hF, 32'h0000_3000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b1);
      step();
    end
    set_store(1'b1, 4'hF, 32'h0000_3100, 32'h0000_0BAD, 1'b0);
    dcache_ready = 1'b1;
    sample();
    check("t2_full", full, 1'b1);
    check("t2_store_ready", store_ready, 1'b0);
    check("t2_count_full", count, DEPTH);
    step();
    idle_store();
    dcache_ready = 1'b0;
    sample();
    check("t2_count_after_deq", count, DEPTH - 1);
    check("t2_not_full", full, 1'b0);
    drain(3 * DEPTH);

    // 3: 20 cycles of enqueue with ready held high from empty.
    step();
    dcache_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_store(1'b1, 4'(k + 1), 32'h0000_5000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b1);
      step();
      sample();
      check("t3_count_steady", count, 1);
    end
    idle_store();
    drain(10);

    // 4: byte merge across two entries in the same word.
    step();
    set_store(1'b1, 4'h3, 32'h0000_2000, 32'h0000_AABB, 1'b1);
    step();
    set_store(1'b1, 4'h6, 32'h0000_2002, 32'h00CC_DD00, 1'b1);
    step();
    idle_store();
    query_valid = 1'b1;
    query_addr  = 32'h0000_2000;
    sample();
    check_query("t4_merge", 1'b1, 4'h7, 32'h00CC_DDBB);
    query_addr = 32'h0000_2003;
    sample();
    check_query("t4_merge_offset", 1'b1, 4'h7, 32'h00CC_DDBB);
    query_addr = 32'h0000_2004;
    sample();
    check_query("t4_miss", 1'b0, 4'h0, 32'h0);
    query_valid = 1'b0;
    query_addr  = 32'h0000_2000;
    sample();
    check_query("t4_query_off", 1'b0, 4'h0, 32'h0);

    // 5: head being popped still forwards; same-cycle enqueue does not.
    step();
    query_valid  = 1'b1;
    dcache_ready = 1'b1;
    sample();
    check_query("t5_pop_cycle", 1'b1, 4'h7, 32'h00CC_DDBB);
    step();
    dcache_ready = 1'b0;
    sample();
    check_query("t5_after_pop", 1'b1, 4'h6, 32'h00CC_DD00);
    step();
    set_store(1'b1, 4'hF, 32'h0000_2400, 32'h1234_5678, 1'b1);
    query_addr = 32'h0000_2400;
    sample();
    check_query("t5_enq_cycle", 1'b0, 4'h0, 32'h0);
    step();
    idle_store();
    sample();
    check_query("t5_enq_next", 1'b1, 4'hF, 32'h1234_5678);
    step();
    set_store(1'b1, 4'h1, 32'h0000_2800, 32'h0000_00EE, 1'b1);
    step();
    idle_store();
    sample();
    check("t6_pre_count", count, 3);

    // 6: asynchronous reset mid-cycle discards everything.
    step();
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_empty", empty, 1'b1);
    check("t6_rst_valid", dcache_req.valid, 1'b0);
    check("t6_rst_count", count, 0);
    check("t6_rst_store_ready", store_ready, 1'b1);
    step();
    rst = 1'b1;
    query_addr = 32'h0000_2400;
    sample();
    check_query("t6_query_flushed", 1'b0, 4'h0, 32'h0);
    query_valid = 1'b0;
    step();
    set_store(1'b1, 4'hF, 32'h0000_4000, 32'hCAFE_F00D, 1'b1);
    step();
    idle_store();
    sample();
    check("t6_head_addr", dcache_req.waddr, 32'h0000_4000);
    check("t6_count", count, 1);
    drain(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
